// File: rtl/color_seq_pkg.sv
// Shared definitions for the colour sequencer: FSM state encoding,
// sequence-mode and direction constants, and a range helper.
// Optional build macro used by this block: COLOR_SEQ_DWELL_RT_EN
// (adds a run-time dwell_cfg input to color_sequencer).
package color_seq_pkg;

    // Sequencer run state.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Sequence mode as presented on the mode input.
    localparam logic MODE_WRAP     = 1'b0;
    localparam logic MODE_PINGPONG = 1'b1;

    // Travel direction through the colour range.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // True when value lies inside the inclusive range [lo, hi].
    function automatic logic in_range(input int value, input int lo, input int hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell timer: counts cycles of the current colour hold and emits a
// one-cycle tick on the counting cycle that reaches the terminal count.
// The terminal count is held in a register so a new dwell length can be
// loaded at a colour boundary without disturbing a hold in progress.
module dwell_timer #(
    parameter int DWELL_W  = 8,
    parameter int INIT_LIM = 1
) (
    input  logic               clk,
    input  logic               rst,       // asynchronous, active-low
    input  logic               i_clear,   // restart the hold from zero
    input  logic               i_count,   // count this cycle
    input  logic               i_load,    // capture i_lim as the terminal count
    input  logic [DWELL_W-1:0] i_lim,     // terminal count = dwell length - 1
    output logic               o_tick     // terminal count reached while counting
);

    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] r_lim;

    // The tick is only meaningful on a counting cycle.
    always_comb begin
        o_tick = i_count && (r_cnt == r_lim);
    end

    // Hold counter: clear wins, otherwise count and roll over at the tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_count) begin
            r_cnt <= o_tick ? '0 : r_cnt + DWELL_W'(1);
        end
    end

    // Terminal-count register, reloaded only at hold boundaries.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lim <= DWELL_W'(INIT_LIM);
        end else if (i_load) begin
            r_lim <= i_lim;
        end
    end

endmodule

// File: rtl/color_sequencer.sv
// Colour sequencer: steps a palette index through [FIRST_COLOR, LAST],
// holding each colour for a dwell period, in wrap or ping-pong order.
// Supports run/idle control, a jump-load handshake with a sticky
// out-of-range flag, and a one-cycle pulse at wrap or reversal.
// Build macro COLOR_SEQ_DWELL_RT_EN replaces the DWELL parameter with a
// run-time dwell_cfg input sampled at colour boundaries and jumps.
module color_sequencer
    import color_seq_pkg::*;
#(
    parameter int COLOR_W     = 4,
    parameter int FIRST_COLOR = 2,
    parameter int NUM_COLORS  = 4,
    parameter int DWELL       = 2,
    parameter int DWELL_W     = 8
) (
    input  logic               clk,
    input  logic               rst,          // asynchronous, active-low
    input  logic               en,
    input  logic               mode,
    input  logic               jump_valid,
    input  logic [COLOR_W-1:0] jump_color,
`ifdef COLOR_SEQ_DWELL_RT_EN
    input  logic [DWELL_W-1:0] dwell_cfg,
`endif
    output logic               jump_ready,
    output logic [COLOR_W-1:0] color,
    output logic               running,
    output logic               wrap,
    output logic               jump_err
);

    localparam int                 LAST_COLOR = FIRST_COLOR + NUM_COLORS - 1;
    localparam logic [COLOR_W-1:0] C_FIRST    = COLOR_W'(FIRST_COLOR);
    localparam logic [COLOR_W-1:0] C_LAST     = COLOR_W'(LAST_COLOR);
    localparam logic [0:0]         S_IDLE     = ST_IDLE;
    localparam logic [0:0]         S_RUN      = ST_RUN;

    // Registered state and outputs
    logic [0:0]         r_state;
    logic               r_running;
    logic [COLOR_W-1:0] r_color;
    logic               r_dir;
    logic               r_wrap;
    logic               r_jump_err;
    logic               r_jump_ready;

    // Combinational control
    logic [0:0]         w_state_next;
    logic               w_jump_acc;
    logic               w_jump_in_range;
    logic               w_count;
    logic               w_tick;
    logic               w_adv;
    logic               w_go_up;
    logic [COLOR_W-1:0] w_adv_color;
    logic               w_adv_dir;
    logic               w_adv_wrap;
    logic               w_lim_load;
    logic [DWELL_W-1:0] w_lim;

    assign jump_ready = r_jump_ready;
    assign color      = r_color;
    assign running    = r_running;
    assign wrap       = r_wrap;
    assign jump_err   = r_jump_err;

    // Handshake and advance qualification; an accepted jump suppresses the advance.
    always_comb begin
        w_jump_acc      = jump_valid && r_jump_ready;
        w_jump_in_range = in_range(int'(jump_color), FIRST_COLOR, LAST_COLOR);
        w_count         = (r_state == S_RUN) && en && !w_jump_acc;
        w_adv           = w_count && w_tick;
    end

    // Dwell length source: parameter constant, or run-time config with 0 read as 1.
`ifdef COLOR_SEQ_DWELL_RT_EN
    always_comb begin
        w_lim_load = w_adv || w_jump_acc;
        w_lim      = (dwell_cfg == '0) ? '0 : dwell_cfg - DWELL_W'(1);
    end
`else
    always_comb begin
        w_lim_load = 1'b0;
        w_lim      = DWELL_W'(DWELL - 1);
    end
`endif

    dwell_timer #(
        .DWELL_W  (DWELL_W),
        .INIT_LIM (DWELL - 1)
    ) u_dwell_timer (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_jump_acc),
        .i_count (w_count),
        .i_load  (w_lim_load),
        .i_lim   (w_lim),
        .o_tick  (w_tick)
    );

    // Run/idle transitions follow en; colour and dwell are left untouched.
    always_comb begin
        w_state_next = r_state;
        if (r_state == S_IDLE) begin
            if (en) begin
                w_state_next = S_RUN;
            end
        end else begin
            if (!en) begin
                w_state_next = S_IDLE;
            end
        end
    end

    // Next colour at an advance. Ping-pong direction is pinned at the
    // endpoints so a jump that leaves a stale direction can never walk
    // the index outside the range.
    always_comb begin
        w_adv_color = r_color;
        w_adv_dir   = DIR_UP;
        w_adv_wrap  = 1'b0;
        w_go_up     = 1'b1;
        if (NUM_COLORS == 1) begin
            w_adv_color = C_FIRST;
            w_adv_wrap  = 1'b1;
        end else if (mode == MODE_PINGPONG) begin
            if (r_color == C_FIRST) begin
                w_go_up = 1'b1;
            end else if (r_color == C_LAST) begin
                w_go_up = 1'b0;
            end else begin
                w_go_up = (r_dir == DIR_UP);
            end
            w_adv_color = w_go_up ? r_color + COLOR_W'(1) : r_color - COLOR_W'(1);
            if (w_adv_color == C_LAST) begin
                w_adv_dir  = DIR_DOWN;
                w_adv_wrap = 1'b1;
            end else if (w_adv_color == C_FIRST) begin
                w_adv_dir  = DIR_UP;
                w_adv_wrap = 1'b1;
            end else begin
                w_adv_dir = w_go_up ? DIR_UP : DIR_DOWN;
            end
        end else begin
            if (r_color == C_LAST) begin
                w_adv_color = C_FIRST;
                w_adv_wrap  = 1'b1;
            end else begin
                w_adv_color = r_color + COLOR_W'(1);
            end
        end
    end

    // FSM state, running flag and jump-ready flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_running    <= 1'b0;
            r_jump_ready <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_running    <= (w_state_next == S_RUN);
            r_jump_ready <= 1'b1;
        end
    end

    // Colour index and direction: jump load takes priority over an advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_color <= C_FIRST;
            r_dir   <= DIR_UP;
        end else if (w_jump_acc) begin
            r_color <= w_jump_in_range ? jump_color : C_FIRST;
            if (mode == MODE_PINGPONG) begin
                if (jump_color == C_FIRST) begin
                    r_dir <= DIR_UP;
                end else if (jump_color == C_LAST) begin
                    r_dir <= DIR_DOWN;
                end
            end
        end else if (w_adv) begin
            r_color <= w_adv_color;
            r_dir   <= w_adv_dir;
        end
    end

    // Wrap pulse only on a real advance; sticky error on out-of-range jumps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrap     <= 1'b0;
            r_jump_err <= 1'b0;
        end else begin
            r_wrap <= w_adv && w_adv_wrap;
            if (w_jump_acc && !w_jump_in_range) begin
                r_jump_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_color_sequencer.sv
// Self-checking bench for color_sequencer: directed steps from the test
// plan plus a randomized stretch, checked against a behavioural model.
module tb_color_sequencer;

    localparam int FIRST = 2;
    localparam int LAST  = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic       jv = 1'b0;
    logic [3:0] jc = 4'd0;
`ifdef COLOR_SEQ_DWELL_RT_EN
    logic [7:0] dwell_cfg = 8'd2;
    logic [7:0] one_cfg = 8'd3;
`endif

    logic [3:0] color,   f_color,   o_color;
    logic       running, f_running, o_running;
    logic       wrap,    f_wrap,    o_wrap;
    logic       jump_ready, f_jump_ready, o_jump_ready;
    logic       jump_err,   f_jump_err,   o_jump_err;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the main instance
    int m_color, m_age, m_dwell;
    bit m_run, m_up, m_wrap, m_err, m_ready;

    always #5 clk = ~clk;

    // Main instance: range 2..5, dwell 2
    color_sequencer #(.COLOR_W(4), .FIRST_COLOR(2), .NUM_COLORS(4), .DWELL(2), .DWELL_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .jump_valid(jv), .jump_color(jc),
`ifdef COLOR_SEQ_DWELL_RT_EN
        .dwell_cfg(dwell_cfg),
`endif
        .jump_ready(jump_ready), .color(color), .running(running), .wrap(wrap), .jump_err(jump_err));

    // Ping-pong instance with single-cycle dwell
    color_sequencer #(.COLOR_W(4), .FIRST_COLOR(2), .NUM_COLORS(4), .DWELL(1), .DWELL_W(8)) u_fast (
        .clk(clk), .rst(rst), .en(en), .mode(1'b1), .jump_valid(1'b0), .jump_color(4'd0),
`ifdef COLOR_SEQ_DWELL_RT_EN
        .dwell_cfg(8'd1),
`endif
        .jump_ready(f_jump_ready), .color(f_color), .running(f_running), .wrap(f_wrap), .jump_err(f_jump_err));

    // Single-colour instance: colour 7, dwell 3
    color_sequencer #(.COLOR_W(4), .FIRST_COLOR(7), .NUM_COLORS(1), .DWELL(3), .DWELL_W(8)) u_one (
        .clk(clk), .rst(rst), .en(en), .mode(1'b0), .jump_valid(1'b0), .jump_color(4'd0),
`ifdef COLOR_SEQ_DWELL_RT_EN
        .dwell_cfg(one_cfg),
`endif
        .jump_ready(o_jump_ready), .color(o_color), .running(o_running), .wrap(o_wrap), .jump_err(o_jump_err));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int eff_cfg();
`ifdef COLOR_SEQ_DWELL_RT_EN
        return (dwell_cfg == 8'd0) ? 1 : int'(dwell_cfg);
`else
        return 2;
`endif
    endfunction

    task automatic model_reset();
        m_run = 0; m_color = FIRST; m_age = 0; m_dwell = 2;
        m_up = 1; m_wrap = 0; m_err = 0; m_ready = 0;
    endtask

    // One clock of the model from the inputs currently applied.
    task automatic model_step();
        bit acc;
        int step;
        int cfg;
        cfg = eff_cfg();
        acc = jv && m_ready;
        m_wrap = 0;
        if (acc) begin
            if (int'(jc) < FIRST || int'(jc) > LAST) begin
                m_color = FIRST;
                m_err = 1;
            end else begin
                m_color = int'(jc);
            end
            if (mode && int'(jc) == FIRST) m_up = 1;
            else if (mode && int'(jc) == LAST) m_up = 0;
            m_age = 0;
            m_dwell = cfg;
        end else if (m_run && en) begin
            if (m_age + 1 < m_dwell) begin
                m_age++;
            end else begin
                m_age = 0;
                m_dwell = cfg;
                if (!mode) begin
                    m_up = 1;
                    m_color = (m_color == LAST) ? FIRST : m_color + 1;
                    m_wrap = (m_color == FIRST);
                end else begin
                    if (m_color == FIRST) step = 1;
                    else if (m_color == LAST) step = -1;
                    else step = m_up ? 1 : -1;
                    m_color += step;
                    if (m_color == FIRST || m_color == LAST) begin
                        m_wrap = 1;
                        m_up = (m_color == FIRST);
                    end else begin
                        m_up = (step > 0);
                    end
                end
            end
        end
        m_run = en;
        m_ready = 1;
    endtask

    // Advance one clock (called at a falling edge) and compare at the next falling edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("color", color, m_color);
        chk("running", running, m_run);
        chk("wrap", wrap, m_wrap);
        chk("jump_err", jump_err, m_err);
        chk("jump_ready", jump_ready, m_ready);
    endtask

    initial begin
        int seq_wrap[10] = '{2, 2, 3, 3, 4, 4, 5, 5, 2, 2};
        int seq_pp[8]    = '{2, 3, 4, 5, 4, 3, 2, 3};
        bit found;
        bit one_wrap;

        model_reset();
        #1 rst = 1'b0;
        #2;
        chk("rst_color", color, 2);
        chk("rst_running", running, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_jump_err", jump_err, 0);
        chk("rst_jump_ready", jump_ready, 0);

        @(negedge clk);
        rst = 1'b1;
        cycle();
        cycle();

        // Wrap sequence on main; ping-pong on u_fast; single colour on u_one
        en = 1'b1;
        mode = 1'b0;
        for (int i = 0; i < 15; i++) begin
            cycle();
            if (i < 10) chk($sformatf("wrap_seq%0d", i), color, seq_wrap[i]);
            if (i < 8) begin
                chk($sformatf("pp_color%0d", i), f_color, seq_pp[i]);
                chk($sformatf("pp_wrap%0d", i), f_wrap, (i == 3 || i == 6) ? 1 : 0);
                chk("pp_running", f_running, 1);
            end
            chk("one_color", o_color, 7);
            chk("one_running", o_running, 1);
`ifdef COLOR_SEQ_DWELL_RT_EN
            one_wrap = (i == 3 || i == 6 || i >= 9);
            if (i == 7) one_cfg = 8'd1;
`else
            one_wrap = (i > 0) && (i % 3 == 0);
`endif
            chk($sformatf("one_wrap%0d", i), o_wrap, one_wrap);
        end
        chk("aux_ready", f_jump_ready & o_jump_ready, 1);
        chk("aux_err", f_jump_err | o_jump_err, 0);

        // Drop en on colour 4 mid-dwell, then resume
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_color == 4 && m_age == 1 && m_run) found = 1;
            else cycle();
        end
        chk("wait_c4", found, 1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("idle_color", color, 4);
            chk("idle_running", running, 0);
        end
        en = 1'b1;
        cycle();
        chk("resume_color", color, 4);
        chk("resume_running", running, 1);
        cycle();
        chk("resume_next", color, 5);

        // Jump coinciding with a scheduled advance from 3
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_color == 3 && m_age == 1 && m_run) found = 1;
            else cycle();
        end
        chk("wait_c3", found, 1);
        jv = 1'b1;
        jc = 4'd4;
        cycle();
        chk("jump_color", color, 4);
        chk("jump_nowrap", wrap, 0);
        jv = 1'b0;
        cycle();
        chk("jump_hold", color, 4);
        cycle();
        chk("jump_adv", color, 5);

        // Out-of-range jump and sticky error
        jv = 1'b1;
        jc = 4'd9;
        cycle();
        chk("oor_color", color, 2);
        chk("oor_err", jump_err, 1);
        jv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("err_sticky", jump_err, 1);
        end

        // Randomized stretch
        for (int i = 0; i < 300; i++) begin
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            jv = ($urandom_range(0, 6) == 0);
            jc = 4'($urandom_range(0, 15));
`ifdef COLOR_SEQ_DWELL_RT_EN
            dwell_cfg = 8'($urandom_range(0, 3));
`endif
            cycle();
        end

        // Asynchronous reset while running on colour 5
        en = 1'b1;
        mode = 1'b0;
        jv = 1'b0;
`ifdef COLOR_SEQ_DWELL_RT_EN
        dwell_cfg = 8'd2;
`endif
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_color == 5 && m_run) found = 1;
            else cycle();
        end
        chk("wait_c5", found, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_color", color, 2);
        chk("arst_running", running, 0);
        chk("arst_wrap", wrap, 0);
        chk("arst_jump_err", jump_err, 0);
        chk("arst_jump_ready", jump_ready, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/color_sequencer.md
Name: color_sequencer

Overview:
- Parametrised successor to the fixed 4-colour counter: steps a colour index through a configurable contiguous range, holding each colour for a programmable dwell.
- Adds enable/idle control, wrap and ping-pong modes, a jump-load handshake, and a wrap/reversal pulse.
- Sits between the frame/pixel timing logic and the palette lookup. The colour index drives the palette address.

Parameters:
- COLOR_W, 4, width of colour index.
- FIRST_COLOR, 2, lowest colour index in the sequence.
- NUM_COLORS, 4, number of colours in the sequence; must be ≥1, and FIRST_COLOR+NUM_COLORS-1 must be < 2**COLOR_W.
- DWELL, 2, clock cycles each colour is held; must be ≥1.
- DWELL_W, 8, width of the dwell counter; DWELL must be ≤ 2**DWELL_W.

Ports:
- clk, in, 1, clock; all state updates on its rising edge.
- rst, in, 1, reset; asynchronous, active-low.
- en, in, 1, run enable.
- mode, in, 1, sequence mode: 0 = wrap, 1 = ping-pong.
- jump_valid, in, 1, jump request.
- jump_color, in, COLOR_W, jump target colour.
- jump_ready, out, 1, jump accept.
- color, out, COLOR_W, current colour index.
- running, out, 1, high while in state RUN.
- wrap, out, 1, one-cycle pulse at wrap or direction reversal.
- jump_err, out, 1, sticky flag: an out-of-range jump was accepted.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, color=FIRST_COLOR, dwell_cnt=0, dir=up, wrap=0, jump_err=0, running=0. LAST = FIRST_COLOR+NUM_COLORS-1.
- States:
  - IDLE: color held, dwell_cnt held. Moves to RUN on en=1.
  - RUN: moves to IDLE on en=0. color and dwell_cnt are retained, so re-enabling resumes mid-dwell.
  - running = (state==RUN), registered.
- Advance in RUN:
  - Each cycle dwell_cnt increments.
  - When dwell_cnt==DWELL-1: dwell_cnt←0 and color advances. Each colour is therefore visible exactly DWELL cycles.
  - DWELL=1 advances every cycle.
- Wrap mode (mode=0):
  - color+1; at LAST, next is FIRST_COLOR and wrap=1 for that cycle.
  - dir is forced to up at each advance.
- Ping-pong mode (mode=1):
  - Sequence is FIRST..LAST..FIRST with no repeated endpoint (e.g. 2,3,4,5,4,3,2,3).
  - dir flips when the advance lands on LAST or FIRST; wrap=1 in that cycle.
- Mode change is sampled only at an advance; no glitch mid-dwell.
- NUM_COLORS=1: color constant; wrap pulses at every advance.
- Jump handshake:
  - jump_ready=1 whenever rst=1.
  - On jump_valid&&jump_ready, next cycle color←jump_color and dwell_cnt←0. Accepted in IDLE or RUN; state is unchanged.
  - dir is unchanged, except it is forced to up if jump_color==FIRST and to down if jump_color==LAST in ping-pong mode.
  - Out of range (jump_color<FIRST or >LAST): color←FIRST_COLOR and jump_err←1. jump_err clears only on reset.
  - A jump accepted in the same cycle as an advance wins; no advance and no wrap pulse that cycle.
- wrap is registered and is 0 in IDLE.
- All outputs are registered.

Optional Feature:
- Macro: COLOR_SEQ_DWELL_RT_EN.
- Defined:
  - Adds input dwell_cfg [DWELL_W-1:0], which replaces the DWELL parameter.
  - dwell_cfg is sampled at each advance and at jump acceptance; changes mid-dwell take effect at the next colour.
  - dwell_cfg=0 is treated as 1.
- Undefined: no dwell_cfg port; dwell is the DWELL parameter constant.

Decomposition:
- Package color_seq_pkg:
  - state enum (IDLE, RUN).
  - mode constants MODE_WRAP=0, MODE_PINGPONG=1.
  - direction constants.
- One natural sub-module, dwell_timer: the DWELL_W counter with load/clear, emitting a one-cycle tick at terminal count. The sequencer FSM stays in color_sequencer.

Test Plan:
- Reset/defaults, then en=1, mode=0: color sequence 2,2,3,3,4,4,5,5,2,2; wrap=1 in the cycle color returns to 2; running=1 from the first cycle after en.
- mode=1, DWELL=1: color 2,3,4,5,4,3,2,3; wrap=1 on the cycles showing 5 and 2.
- en dropped mid-dwell on colour 4 (first cycle) for 3 cycles, then re-raised: color stays 4, running=0 throughout; after resume, 4 is held 1 more cycle, then 5.
- Jump: jump_valid=1, jump_color=4 coinciding with a scheduled advance from 3: color=4 next cycle, dwell restarted, no wrap; jump_color=9 → color=2, jump_err=1, and it persists.
- rst asserted asynchronously mid-RUN on color 5: color=2, running=0, wrap=0, jump_err=0 immediately, without waiting for a clock edge.
- NUM_COLORS=1, FIRST_COLOR=7, DWELL=3: color constantly 7, wrap pulses every 3 cycles; with COLOR_SEQ_DWELL_RT_EN defined, dwell_cfg changed 3→1 mid-dwell takes effect after the current hold.
